// File: rtl/proj_pkg.sv
// Shared types and base helpers for the MinHash fragment projection path.
// Contents: extender FSM state type, 2-bit base codes, one-hot and complement helpers.
// No logic of its own; imported by frag_extender_stream and base_onehot.
package proj_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ext_state_e;

  localparam int BASE_W   = 2;
  localparam int ONEHOT_W = 4;

  localparam logic [BASE_W-1:0] BASE_A = 2'b00;
  localparam logic [BASE_W-1:0] BASE_C = 2'b01;
  localparam logic [BASE_W-1:0] BASE_G = 2'b10;
  localparam logic [BASE_W-1:0] BASE_T = 2'b11;

  function automatic logic [ONEHOT_W-1:0] base_to_onehot(input logic [BASE_W-1:0] b);
    logic [ONEHOT_W-1:0] oh;
    oh = '0;
    case (b)
      BASE_A:  oh = 4'b0001;
      BASE_C:  oh = 4'b0010;
      BASE_G:  oh = 4'b0100;
      BASE_T:  oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  // A<->T and C<->G; with this coding that is a bitwise inversion.
  function automatic logic [BASE_W-1:0] base_complement(input logic [BASE_W-1:0] b);
    logic [BASE_W-1:0] c;
    c = BASE_A;
    case (b)
      BASE_A:  c = BASE_T;
      BASE_C:  c = BASE_G;
      BASE_G:  c = BASE_C;
      BASE_T:  c = BASE_A;
      default: c = BASE_A;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/base_onehot.sv
// Combinational encoder: one 2-bit base code to a 4-bit one-hot base.
// Ports: base (encoded base in), onehot (one-hot base out). Latency 0.
// No handshake; purely combinational.
module base_onehot
  import proj_pkg::*;
(
  input  logic [BASE_W-1:0]   base,
  output logic [ONEHOT_W-1:0] onehot
);

  assign onehot = base_to_onehot(base);

endmodule

// File: rtl/frag_extender_stream.sv
// Streaming fragment extender: for each enabled in-range k-mer slot, emits the whole
// fragment as PARTS one-hot GFM beats tagged with the centred signed index.
// Latency: accept at edge k gives the first beat in cycle k+1; one IDLE cycle between
// transactions. Backpressure: out_* hold while out_valid && !out_ready; in_ready is low
// while streaming and for one cycle after accepting a transaction with nothing to stream.
// Ports: clk/rst_n; in_valid/in_ready/in_fragment/in_kmer_indices/in_index_mask
// [/in_revcomp]; out_valid/out_ready/out_index/out_gfm/out_part/out_idx_last/out_last;
// err_oor. Optional feature macro: FRAG_EXT_REVCOMP_EN (reverse-complement streaming).
module frag_extender_stream
  import proj_pkg::*;
#(
  parameter int FRAG_SIZE      = 8,
  parameter int KMER_SIZE      = 4,
  parameter int INDICES_COUNT  = 4,
  parameter int BASE_LEN       = 2,
  parameter int ONE_HOT_LEN    = 4,
  parameter int BASES_PER_BEAT = 2,
  localparam int FRAG_LEN_BITS     = FRAG_SIZE * BASE_LEN,
  localparam int INDICE_LEN        = $clog2(FRAG_SIZE),
  localparam int SIGNED_INDICE_LEN = INDICE_LEN + 1,
  localparam int PARTS             = FRAG_SIZE / BASES_PER_BEAT,
  localparam int MAX_IDX           = FRAG_SIZE - KMER_SIZE,
  localparam int PART_W            = (PARTS > 1) ? $clog2(PARTS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [FRAG_LEN_BITS-1:0]              in_fragment,
  input  logic [INDICES_COUNT*INDICE_LEN-1:0]   in_kmer_indices,
  input  logic [INDICES_COUNT-1:0]              in_index_mask,
`ifdef FRAG_EXT_REVCOMP_EN
  input  logic                                  in_revcomp,
`endif
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [SIGNED_INDICE_LEN-1:0]          out_index,
  output logic [BASES_PER_BEAT*ONE_HOT_LEN-1:0] out_gfm,
  output logic [PART_W-1:0]                     out_part,
  output logic                                  out_idx_last,
  output logic                                  out_last,
  output logic                                  err_oor
);

  localparam int SLOT_W = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
  localparam logic [INDICE_LEN-1:0]        MAX_IDX_I = INDICE_LEN'(MAX_IDX);
  localparam logic [SIGNED_INDICE_LEN-1:0] MAX_IDX_S = SIGNED_INDICE_LEN'(MAX_IDX);
  localparam logic [SIGNED_INDICE_LEN-1:0] HALF_S    = SIGNED_INDICE_LEN'(MAX_IDX / 2);
  localparam logic [PART_W-1:0]            LAST_PART = PART_W'(PARTS - 1);

  ext_state_e state_q, state_d;

  logic [BASE_LEN-1:0]   frag_q [FRAG_SIZE];
  logic [INDICE_LEN-1:0] idx_q  [INDICES_COUNT];
  logic [INDICES_COUNT-1:0] mask_q;
  logic [PART_W-1:0]     part_q;
  logic                  err_q;
  // Set for one cycle after accepting a transaction that has nothing to stream.
  logic                  flush_q;
`ifdef FRAG_EXT_REVCOMP_EN
  logic                  revcomp_q;
`endif

  logic [INDICES_COUNT-1:0] oor_vec;
  logic [INDICES_COUNT-1:0] mask_in;
  logic                     accept_in;
  logic                     beat_acc;
  logic                     last_part;
  logic [SLOT_W-1:0]        cur_slot;
  logic [INDICES_COUNT-1:0] cur_bit;
  logic [INDICES_COUNT-1:0] mask_after;
  logic                     streaming;

  // Out-of-range slots are dropped from the mask at capture time.
  always_comb begin
    oor_vec = '0;
    for (int i = 0; i < INDICES_COUNT; i++) begin
      oor_vec[i] = in_kmer_indices[i*INDICE_LEN +: INDICE_LEN] > MAX_IDX_I;
    end
  end

  assign mask_in   = in_index_mask & ~oor_vec;
  assign accept_in = (state_q == IDLE) && in_valid && in_ready;
  assign beat_acc  = (state_q == STREAM) && out_ready;
  assign last_part = (part_q == LAST_PART);
  assign streaming = (state_q == STREAM);

  // Lowest set bit of the remaining mask selects the current slot.
  always_comb begin
    cur_slot = '0;
    cur_bit  = '0;
    for (int i = INDICES_COUNT - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        cur_slot = SLOT_W'(i);
        cur_bit  = '0;
        cur_bit[i] = 1'b1;
      end
    end
  end

  assign mask_after = mask_q & ~cur_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !flush_q;
        if (accept_in && (mask_in != '0)) state_d = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (beat_acc && last_part && (mask_after == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAG_SIZE; i++) frag_q[i] <= '0;
      for (int i = 0; i < INDICES_COUNT; i++) idx_q[i] <= '0;
      mask_q  <= '0;
      part_q  <= '0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
`ifdef FRAG_EXT_REVCOMP_EN
      revcomp_q <= 1'b0;
`endif
    end else begin
      err_q   <= accept_in && ((in_index_mask & oor_vec) != '0);
      flush_q <= accept_in && (mask_in == '0);
      if (accept_in) begin
        for (int i = 0; i < FRAG_SIZE; i++) frag_q[i] <= in_fragment[i*BASE_LEN +: BASE_LEN];
        for (int i = 0; i < INDICES_COUNT; i++) idx_q[i] <= in_kmer_indices[i*INDICE_LEN +: INDICE_LEN];
        mask_q <= mask_in;
        part_q <= '0;
`ifdef FRAG_EXT_REVCOMP_EN
        revcomp_q <= in_revcomp;
`endif
      end else if (beat_acc) begin
        if (last_part) begin
          part_q <= '0;
          mask_q <= mask_after;
        end else begin
          part_q <= part_q + 1'b1;
        end
      end
    end
  end

  // Beat data: bases [part*BASES_PER_BEAT +: BASES_PER_BEAT], lowest base in the LSBs.
  logic [BASES_PER_BEAT*ONE_HOT_LEN-1:0] gfm_raw;

  for (genvar b = 0; b < BASES_PER_BEAT; b++) begin : g_beat
    logic [INDICE_LEN-1:0] pos;
    logic [BASE_LEN-1:0]   base_sel;
    assign pos = INDICE_LEN'(part_q * BASES_PER_BEAT + b);
`ifdef FRAG_EXT_REVCOMP_EN
    assign base_sel = revcomp_q ? base_complement(frag_q[INDICE_LEN'(FRAG_SIZE - 1) - pos])
                                : frag_q[pos];
`else
    assign base_sel = frag_q[pos];
`endif
    base_onehot u_enc (
      .base   (base_sel),
      .onehot (gfm_raw[b*ONE_HOT_LEN +: ONE_HOT_LEN])
    );
  end

  logic [SIGNED_INDICE_LEN-1:0] eff_idx;
`ifdef FRAG_EXT_REVCOMP_EN
  // Reverse-complement mirrors the k-mer start before centring.
  assign eff_idx = revcomp_q ? (MAX_IDX_S - {1'b0, idx_q[cur_slot]}) : {1'b0, idx_q[cur_slot]};
`else
  assign eff_idx = {1'b0, idx_q[cur_slot]};
`endif

  // Outputs are forced to zero outside STREAM so reset/idle values are all zero.
  assign out_index    = streaming ? (eff_idx - HALF_S) : '0;
  assign out_gfm      = streaming ? gfm_raw : '0;
  assign out_part     = streaming ? part_q : '0;
  assign out_idx_last = streaming && last_part;
  assign out_last     = streaming && last_part && (mask_after == '0);
  assign err_oor      = err_q;

endmodule

// File: tb/tb_frag_extender_stream.sv
// Directed self-checking bench for frag_extender_stream with default parameters.
module tb_frag_extender_stream;

  localparam int PARTS = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_fragment;
  logic [11:0] in_kmer_indices;
  logic [3:0]  in_index_mask;
`ifdef FRAG_EXT_REVCOMP_EN
  logic        in_revcomp;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic [7:0]  out_gfm;
  logic [1:0]  out_part;
  logic        out_idx_last;
  logic        out_last;
  logic        err_oor;

  int compared;
  int mismatched;

  frag_extender_stream dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_fragment     (in_fragment),
    .in_kmer_indices (in_kmer_indices),
    .in_index_mask   (in_index_mask),
`ifdef FRAG_EXT_REVCOMP_EN
    .in_revcomp      (in_revcomp),
`endif
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_index       (out_index),
    .out_gfm         (out_gfm),
    .out_part        (out_part),
    .out_idx_last    (out_idx_last),
    .out_last        (out_last),
    .err_oor         (err_oor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_out_gfm"}, out_gfm, 0);
    chk({tag, "_out_part"}, out_part, 0);
    chk({tag, "_out_idx_last"}, out_idx_last, 0);
    chk({tag, "_out_last"}, out_last, 0);
  endtask

  // Offer one transaction at the current sample point; returns just after the accept edge.
  task automatic send(input string tag, input logic [15:0] frag, input logic [11:0] idx,
                      input logic [3:0] mask, input logic rc);
    in_fragment     = frag;
    in_kmer_indices = idx;
    in_index_mask   = mask;
`ifdef FRAG_EXT_REVCOMP_EN
    in_revcomp      = rc;
`else
    if (rc) $display("note: revcomp request ignored in this build");
`endif
    in_valid = 1'b1;
    chk({tag, "_ready_before"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Walks the beat stream, checking every visible beat (including stalled ones)
  // against the expected per-part gfm and per-slot index tables.
  task automatic stream_check(input string tag, input logic [7:0] g[4], input logic [3:0] ix[4],
                              input int nslots, input bit toggle, input bit exp_err,
                              input int stop_after, output int cycles);
    int n, total, limit, cyc;
    total = nslots * PARTS;
    limit = (stop_after > 0) ? stop_after : total;
    n = 0;
    cyc = 0;
    while (n < limit && cyc < 200) begin
      out_ready = toggle ? cyc[0] : 1'b1;
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_err"}, err_oor, (cyc == 0) ? exp_err : 1'b0);
      chk({tag, "_gfm"}, out_gfm, g[n % PARTS]);
      chk({tag, "_index"}, out_index, ix[n / PARTS]);
      chk({tag, "_part"}, out_part, n % PARTS);
      chk({tag, "_idx_last"}, out_idx_last, (n % PARTS) == PARTS - 1);
      chk({tag, "_last"}, out_last, n == total - 1);
      @(posedge clk); #1;
      cyc++;
      if (out_ready) n++;
    end
    chk({tag, "_beats"}, n, limit);
    cycles = cyc;
    out_ready = 1'b1;
    if (stop_after == 0) begin
      chk({tag, "_post_valid"}, out_valid, 0);
      chk({tag, "_post_ready"}, in_ready, 1);
    end
  endtask

  initial begin
    logic [7:0] g_fwd [4];
    logic [3:0] ix_all [4];
    logic [3:0] ix_0101 [4];
    logic [3:0] ix_oor [4];
    int cyc;

    compared   = 0;
    mismatched = 0;
    g_fwd   = '{8'h21, 8'h84, 8'h48, 8'h12};
    ix_all  = '{4'hE, 4'hF, 4'h0, 4'h1};
    ix_0101 = '{4'hE, 4'h0, 4'h0, 4'h0};
    ix_oor  = '{4'hE, 4'h0, 4'h1, 4'h0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_fragment = '0;
    in_kmer_indices = '0;
    in_index_mask = '0;
`ifdef FRAG_EXT_REVCOMP_EN
    in_revcomp = 1'b0;
`endif
    out_ready = 1'b1;

    #12;
    check_idle_zero("reset");
    chk("reset_err", err_oor, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("post_reset");

    // All four slots, continuous ready: 16 beats, ready back the cycle after the last.
    send("t1", 16'h1BE4, {3'd3, 3'd2, 3'd1, 3'd0}, 4'hF, 1'b0);
    stream_check("t1", g_fwd, ix_all, 4, 1'b0, 1'b0, 0, cyc);
    chk("t1_cycles", cyc, 16);

    // Slots 0 and 2 only.
    send("t2", 16'h1BE4, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0101, 1'b0);
    stream_check("t2", g_fwd, ix_0101, 2, 1'b0, 1'b0, 0, cyc);
    chk("t2_cycles", cyc, 8);

    // Empty mask: no beats, in_ready low for exactly one cycle.
    send("t3", 16'h1BE4, {3'd3, 3'd2, 3'd1, 3'd0}, 4'h0, 1'b0);
    chk("t3_ready_low", in_ready, 0);
    chk("t3_valid", out_valid, 0);
    chk("t3_err", err_oor, 0);
    @(posedge clk); #1;
    chk("t3_ready_back", in_ready, 1);
    chk("t3_valid2", out_valid, 0);

    // Slot 1 out of range: err pulse, slot skipped.
    send("t4", 16'h1BE4, {3'd3, 3'd2, 3'd5, 3'd0}, 4'hF, 1'b0);
    stream_check("t4", g_fwd, ix_oor, 3, 1'b0, 1'b1, 0, cyc);
    chk("t4_cycles", cyc, 12);
    chk("t4_err_clear", err_oor, 0);

    // Alternating backpressure: same beats, twice the cycles.
    send("t5", 16'h1BE4, {3'd3, 3'd2, 3'd1, 3'd0}, 4'hF, 1'b0);
    stream_check("t5", g_fwd, ix_all, 4, 1'b1, 1'b0, 0, cyc);
    chk("t5_cycles", cyc, 32);

    // Reset while beat 6 is on the output, then a fresh transaction.
    send("t6", 16'h1BE4, {3'd3, 3'd2, 3'd1, 3'd0}, 4'hF, 1'b0);
    stream_check("t6a", g_fwd, ix_all, 4, 1'b0, 1'b0, 5, cyc);
    chk("t6_beat6_part", out_part, 1);
    rst_n = 1'b0;
    #1;
    check_idle_zero("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("t6_after");
    send("t6b", 16'h1BE4, {3'd3, 3'd2, 3'd1, 3'd0}, 4'hF, 1'b0);
    stream_check("t6b", g_fwd, ix_all, 4, 1'b0, 1'b0, 0, cyc);

`ifdef FRAG_EXT_REVCOMP_EN
    begin
      logic [7:0] g_rc [4];
      logic [3:0] ix_rc [4];
      // Output base i = ~base(7-i): bases become T,G,C,A,A,C,G,T.
      g_rc  = '{8'h48, 8'h12, 8'h21, 8'h84};
      ix_rc = '{4'h2, 4'h1, 4'h0, 4'hF};
      send("t7", 16'h1BE4, {3'd3, 3'd2, 3'd1, 3'd0}, 4'hF, 1'b1);
      stream_check("t7", g_rc, ix_rc, 4, 1'b0, 1'b0, 0, cyc);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
